apb_gpio_irq: RTL and testbench



---
 rtl/apb_gpio_irq.sv | 240 ++++++++++++++++++++++++
 tb/tb_apb_gpio_irq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_irq.sv
// ---------------------------------------------------------------------------
// apb_gpio_irq
//   APB3 GPIO slave with per-channel interrupt controller.
//   Each channel has an output data bit and an output enable. Each input bit
//   passes through a synchroniser, then a programmable debounce filter, then
//   an event detector (level/rise/fall/both) that sets a sticky W1C status bit.
//
// Ports:
//   PCLK, PRESET          clock and synchronous active-high reset
//   PSEL, PENABLE, PWRITE APB3 control
//   PADDR[7:0]            byte address (bits [1:0] ignored)
//   PWDATA[31:0]          write data
//   PRDATA[31:0]          read data (combinational, 0 unless PSEL & !PWRITE)
//   PREADY                always 1 (zero wait states)
//   PSLVERR               unmapped access or write to read-only DIN
//   GPIO_IN               asynchronous pin inputs
//   GPIO_OUT, GPIO_OE     output data / enable straight from registers
//   INT                   registered STATUS & IRQ_EN per channel
//   INT_OR                OR of INT
//
// Register map (word offsets):
//   0x00 DOUT  0x04 OE  0x08 DIN(RO)  0x0C IRQ_EN  0x10 IRQ_TYPE
//   0x14 IRQ_POL  0x18 IRQ_BOTH  0x1C STATUS(W1C)  0x20 DEBOUNCE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module apb_gpio_irq #(
  parameter int NUM_GPIO    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [7:0]          PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic [NUM_GPIO-1:0] GPIO_IN,
  output logic [NUM_GPIO-1:0] GPIO_OUT,
  output logic [NUM_GPIO-1:0] GPIO_OE,
  output logic [NUM_GPIO-1:0] INT,
  output logic                INT_OR
);

  localparam logic [5:0] REG_DOUT     = 6'd0;
  localparam logic [5:0] REG_OE       = 6'd1;
  localparam logic [5:0] REG_DIN      = 6'd2;
  localparam logic [5:0] REG_IRQ_EN   = 6'd3;
  localparam logic [5:0] REG_IRQ_TYPE = 6'd4;
  localparam logic [5:0] REG_IRQ_POL  = 6'd5;
  localparam logic [5:0] REG_IRQ_BOTH = 6'd6;
  localparam logic [5:0] REG_STATUS   = 6'd7;
  localparam logic [5:0] REG_DEBOUNCE = 6'd8;

  logic [5:0]          word_addr;
  logic                access_phase;
  logic                addr_mapped;
  logic                bus_err;
  logic                wr_commit;
  logic [NUM_GPIO-1:0] wdata_gpio;

  logic [NUM_GPIO-1:0] dout_reg;
  logic [NUM_GPIO-1:0] oe_reg;
  logic [NUM_GPIO-1:0] irq_en_reg;
  logic [NUM_GPIO-1:0] irq_type_reg;
  logic [NUM_GPIO-1:0] irq_pol_reg;
  logic [NUM_GPIO-1:0] irq_both_reg;
  logic [DB_WIDTH-1:0] db_reg;
  logic [NUM_GPIO-1:0] int_reg;

  logic [NUM_GPIO-1:0] din_filt;
  logic [NUM_GPIO-1:0] status_vec;
  logic [NUM_GPIO-1:0] status_clr;

  // Byte-lane bits and upper write-data bits are not decoded.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // -------------------------------------------------------------------------
  // APB decode
  // -------------------------------------------------------------------------
  assign word_addr    = PADDR[7:2];
  assign access_phase = PSEL & PENABLE;
  assign addr_mapped  = (word_addr <= REG_DEBOUNCE);
  // DIN is read-only, so a write to it is flagged and dropped.
  assign bus_err      = access_phase & (~addr_mapped | (PWRITE & (word_addr == REG_DIN)));
  assign wr_commit    = access_phase & PWRITE & ~bus_err;
  assign wdata_gpio   = PWDATA[NUM_GPIO-1:0];

  assign PREADY  = 1'b1;
  assign PSLVERR = bus_err;

  assign status_clr = (wr_commit && (word_addr == REG_STATUS)) ? wdata_gpio : '0;

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      dout_reg     <= '0;
      oe_reg       <= '0;
      irq_en_reg   <= '0;
      irq_type_reg <= '0;
      irq_pol_reg  <= '0;
      irq_both_reg <= '0;
      db_reg       <= '0;
    end else if (wr_commit) begin
      case (word_addr)
        REG_DOUT:     dout_reg     <= wdata_gpio;
        REG_OE:       oe_reg       <= wdata_gpio;
        REG_IRQ_EN:   irq_en_reg   <= wdata_gpio;
        REG_IRQ_TYPE: irq_type_reg <= wdata_gpio;
        REG_IRQ_POL:  irq_pol_reg  <= wdata_gpio;
        REG_IRQ_BOTH: irq_both_reg <= wdata_gpio;
        REG_DEBOUNCE: db_reg       <= PWDATA[DB_WIDTH-1:0];
        default:      ;
      endcase
    end
  end

  assign GPIO_OUT = dout_reg;
  assign GPIO_OE  = oe_reg;

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && addr_mapped) begin
      case (word_addr)
        REG_DOUT:     PRDATA[NUM_GPIO-1:0] = dout_reg;
        REG_OE:       PRDATA[NUM_GPIO-1:0] = oe_reg;
        REG_DIN:      PRDATA[NUM_GPIO-1:0] = din_filt;
        REG_IRQ_EN:   PRDATA[NUM_GPIO-1:0] = irq_en_reg;
        REG_IRQ_TYPE: PRDATA[NUM_GPIO-1:0] = irq_type_reg;
        REG_IRQ_POL:  PRDATA[NUM_GPIO-1:0] = irq_pol_reg;
        REG_IRQ_BOTH: PRDATA[NUM_GPIO-1:0] = irq_both_reg;
        REG_STATUS:   PRDATA[NUM_GPIO-1:0] = status_vec;
        REG_DEBOUNCE: PRDATA[DB_WIDTH-1:0] = db_reg;
        default:      PRDATA = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel input path: synchroniser -> debounce -> event -> status
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_GPIO; gi++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DB_WIDTH-1:0]    cnt_reg;
    logic                   filt_reg;
    logic                   filt_d_reg;
    logic                   status_reg;
    logic                   sync_out;
    logic                   rise;
    logic                   fall;
    logic                   evt;

    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], GPIO_IN[gi]};
      end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // The filtered value only moves once the synchronised input has
    // disagreed with it for DEBOUNCE+1 consecutive cycles; any agreement
    // restarts the count. The compare uses the live DEBOUNCE register, so a
    // new value applies to counts already in flight.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        cnt_reg    <= '0;
        filt_reg   <= 1'b0;
        filt_d_reg <= 1'b0;
      end else begin
        filt_d_reg <= filt_reg;
        if (sync_out == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == db_reg) begin
          filt_reg <= sync_out;
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_WIDTH'(1);
        end
      end
    end

    assign rise = filt_reg & ~filt_d_reg;
    assign fall = ~filt_reg & filt_d_reg;

    always_comb begin
      evt = 1'b0;
      if (!irq_type_reg[gi]) begin
        evt = (filt_reg == irq_pol_reg[gi]);
      end else if (irq_both_reg[gi]) begin
        evt = rise | fall;
      end else if (irq_pol_reg[gi]) begin
        evt = rise;
      end else begin
        evt = fall;
      end
    end

    // A new event beats a simultaneous W1C so no edge is ever lost.
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        status_reg <= 1'b0;
      end else if (evt) begin
        status_reg <= 1'b1;
      end else if (status_clr[gi]) begin
        status_reg <= 1'b0;
      end
    end

    assign din_filt[gi]   = filt_reg;
    assign status_vec[gi] = status_reg;
  end

  // -------------------------------------------------------------------------
  // Interrupt outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      int_reg <= '0;
    end else begin
      int_reg <= status_vec & irq_en_reg;
    end
  end

  assign INT    = int_reg;
  assign INT_OR = |int_reg;

endmodule

// File: tb/tb_apb_gpio_irq.sv
`timescale 1ns/1ps

module tb_apb_gpio_irq;

  localparam int N   = 8;
  localparam int S   = 2;
  localparam int DBW = 8;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [7:0]    PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [N-1:0]  GPIO_IN = '0;
  logic [N-1:0]  GPIO_OUT;
  logic [N-1:0]  GPIO_OE;
  logic [N-1:0]  INT;
  logic          INT_OR;

  always #5 PCLK = ~PCLK;

  apb_gpio_irq #(.NUM_GPIO(N), .SYNC_STAGES(S), .DB_WIDTH(DBW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .GPIO_IN(GPIO_IN),
    .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .INT(INT), .INT_OR(INT_OR)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit [N-1:0]   m_dout, m_oe, m_en, m_type, m_pol, m_both, m_status, m_int, m_f, m_fd;
  bit [DBW-1:0] m_db;
  int           m_cnt [N];
  bit [N-1:0]   pin_hist [$];   // pin samples, newest first
  bit [N-1:0]   t_s, t_evt, t_clr;
  bit           t_wr;
  int           t_idx;

  function automatic bit model_event(input int i);
    bit rose, fell;
    rose = m_f[i] && !m_fd[i];
    fell = !m_f[i] && m_fd[i];
    if (!m_type[i]) return m_f[i] == m_pol[i];
    if (m_both[i])  return rose || fell;
    return m_pol[i] ? rose : fell;
  endfunction

  function automatic void model_access(input bit wr, input logic [7:0] a,
                                       output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(a) / 4;
    err = (idx > 8) || (wr && idx == 2);
    rd  = '0;
    if (!wr && !err) begin
      case (idx)
        0: rd = 32'(m_dout);
        1: rd = 32'(m_oe);
        2: rd = 32'(m_f);
        3: rd = 32'(m_en);
        4: rd = 32'(m_type);
        5: rd = 32'(m_pol);
        6: rd = 32'(m_both);
        7: rd = 32'(m_status);
        default: rd = 32'(m_db);
      endcase
    end
  endfunction

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_dout = '0; m_oe = '0; m_en = '0; m_type = '0; m_pol = '0; m_both = '0;
      m_status = '0; m_int = '0; m_f = '0; m_fd = '0; m_db = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      pin_hist = {};
      for (int i = 0; i < S; i++) pin_hist.push_back('0);
    end else begin
      t_s   = pin_hist[S-1];
      t_idx = int'(PADDR) / 4;
      t_wr  = PSEL && PENABLE && PWRITE && t_idx <= 8 && t_idx != 2;
      t_clr = (t_wr && t_idx == 7) ? PWDATA[N-1:0] : '0;
      for (int i = 0; i < N; i++) t_evt[i] = model_event(i);
      m_int    = m_status & m_en;
      m_status = t_evt | (m_status & ~t_clr);
      m_fd     = m_f;
      for (int i = 0; i < N; i++) begin
        if (t_s[i] == m_f[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == int'(m_db)) begin m_f[i] = t_s[i]; m_cnt[i] = 0; end
        else m_cnt[i] = (m_cnt[i] + 1) % (1 << DBW);
      end
      if (t_wr) begin
        case (t_idx)
          0: m_dout = PWDATA[N-1:0];
          1: m_oe   = PWDATA[N-1:0];
          3: m_en   = PWDATA[N-1:0];
          4: m_type = PWDATA[N-1:0];
          5: m_pol  = PWDATA[N-1:0];
          6: m_both = PWDATA[N-1:0];
          8: m_db   = PWDATA[DBW-1:0];
          default: ;
        endcase
      end
      pin_hist.push_front(GPIO_IN);
      void'(pin_hist.pop_back());
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t exp_q [$];

  always @(negedge PCLK) begin
    exp_t e;
    if (mon_on) begin
      if (PSEL && PENABLE) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL apb_queue: got access phase expected none queued");
        end else begin
          e = exp_q.pop_front();
          check("prdata", PRDATA, e.rd);
          check("pslverr", 32'(PSLVERR), 32'(e.err));
        end
      end else if (!PSEL) begin
        check("prdata_idle", PRDATA, 32'd0);
      end
      check("pready", 32'(PREADY), 32'd1);
      check("gpio_out", 32'(GPIO_OUT), 32'(m_dout));
      check("gpio_oe", 32'(GPIO_OE), 32'(m_oe));
      check("int", 32'(INT), 32'(m_int));
      check("int_or", 32'(INT_OR), 32'(|m_int));
    end
  end

  // ---------------- APB driver ----------------
  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    exp_t e;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    model_access(wr, a, e.rd, e.err);
    exp_q.push_back(e);
    @(negedge PCLK);
    rd = PRDATA; err = PSLVERR;
    $display("apb %s addr=%h wdata=%h rdata=%h err=%b", wr ? "wr" : "rd", a, d, rd, err);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb(1'b1, a, d, rd, err);
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] rd, output logic err);
    apb(1'b0, a, 32'd0, rd, err);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [7:0]  a;
    logic [31:0] d;

    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    mon_on = 1'b1;
    check("reset_gpio_out", 32'(GPIO_OUT), 32'd0);
    check("reset_int_or", 32'(INT_OR), 32'd0);

    // 1: DOUT / OE, unmapped read
    apb_wr(8'h00, 32'hA5);
    apb_wr(8'h04, 32'h0F);
    check("t1_gpio_out", 32'(GPIO_OUT), 32'hA5);
    check("t1_gpio_oe", 32'(GPIO_OE), 32'h0F);
    apb_rd(8'h00, rd, err);
    check("t1_rd_dout", rd, 32'hA5);
    check("t1_err_dout", 32'(err), 32'd0);
    apb_rd(8'h04, rd, err);
    check("t1_rd_oe", rd, 32'h0F);
    apb_rd(8'h24, rd, err);
    check("t1_err_24", 32'(err), 32'd1);
    check("t1_rd_24", rd, 32'd0);
    apb_wr(8'h08, 32'hFF);   // read-only, must be flagged

    // 2: rising edge on bit 0, latency and W1C
    apb_wr(8'h0C, 32'h01);
    apb_wr(8'h10, 32'h01);
    apb_wr(8'h14, 32'h01);
    apb_wr(8'h20, 32'h00);
    apb_wr(8'h1C, 32'hFF);
    idle(3);
    check("t2_int_or_idle", 32'(INT_OR), 32'd0);
    GPIO_IN[0] = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge PCLK); lat++; #1;
      if (INT_OR) break;
    end
    check("t2_int_latency", 32'(lat), 32'd5);
    apb_wr(8'h1C, 32'h01);
    check("t2_int_or_hold", 32'(INT_OR), 32'd1);
    idle(1);
    check("t2_int_or_clr", 32'(INT_OR), 32'd0);
    idle(4);
    apb_rd(8'h1C, rd, err);
    check("t2_status0_no_reset", 32'(rd[0]), 32'd0);

    // 3: level-high on bit 1
    apb_wr(8'h14, 32'h03);
    GPIO_IN = 8'h03;
    idle(8);
    apb_wr(8'h1C, 32'h02);
    apb_rd(8'h1C, rd, err);
    check("t3_level_reassert", 32'(rd[1]), 32'd1);
    GPIO_IN = 8'h01;
    idle(8);
    apb_wr(8'h1C, 32'h02);
    apb_rd(8'h1C, rd, err);
    check("t3_level_cleared", 32'(rd[1]), 32'd0);

    // 4: debounce on bit 2
    apb_wr(8'h10, 32'h05);
    apb_wr(8'h14, 32'h07);
    apb_wr(8'h20, 32'h05);
    apb_wr(8'h1C, 32'h04);
    @(posedge PCLK); #1; GPIO_IN[2] = 1'b1;
    repeat (4) @(posedge PCLK);
    #1; GPIO_IN[2] = 1'b0;
    idle(15);
    apb_rd(8'h08, rd, err);
    check("t4_glitch_din", 32'(rd[2]), 32'd0);
    apb_rd(8'h1C, rd, err);
    check("t4_glitch_status", 32'(rd[2]), 32'd0);
    @(posedge PCLK); #1; GPIO_IN[2] = 1'b1;
    repeat (6) @(posedge PCLK);
    apb_rd(8'h08, rd, err);
    check("t4_pulse_din", 32'(rd[2]), 32'd1);
    @(posedge PCLK); #1; GPIO_IN[2] = 1'b0;
    idle(20);

    // 5: both edges on bit 3
    apb_wr(8'h20, 32'h00);
    apb_wr(8'h10, 32'h0D);
    apb_wr(8'h18, 32'h08);
    apb_wr(8'h1C, 32'h08);
    GPIO_IN[3] = 1'b1;
    idle(6);
    apb_rd(8'h1C, rd, err);
    check("t5_rise_set", 32'(rd[3]), 32'd1);
    apb_wr(8'h1C, 32'h08);
    apb_rd(8'h1C, rd, err);
    check("t5_w1c", 32'(rd[3]), 32'd0);
    GPIO_IN[3] = 1'b0;
    idle(6);
    apb_rd(8'h1C, rd, err);
    check("t5_fall_set", 32'(rd[3]), 32'd1);
    @(posedge PCLK); #1; GPIO_IN[3] = 1'b1;
    @(posedge PCLK);
    apb_wr(8'h1C, 32'h08);   // commits on the edge where the rise sets STATUS
    apb_rd(8'h1C, rd, err);
    check("t5_set_wins", 32'(rd[3]), 32'd1);

    // 6: reset with pending status and a concurrent DOUT write
    apb_wr(8'h10, 32'h00);
    apb_wr(8'h14, 32'h00);
    apb_wr(8'h0C, 32'hFF);
    apb_wr(8'h04, 32'hFF);
    GPIO_IN = '0;
    idle(8);
    check("t6_int_pending", 32'(INT), 32'hFF);
    begin
      exp_t e;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h3C; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PRESET = 1'b1;
      e.rd = '0; e.err = 1'b0;
      exp_q.push_back(e);
      $display("apb wr addr=00 wdata=0000003c with reset asserted");
      @(posedge PCLK); #1;
      check("t6_gpio_out", 32'(GPIO_OUT), 32'd0);
      check("t6_gpio_oe", 32'(GPIO_OE), 32'd0);
      check("t6_int", 32'(INT), 32'd0);
      check("t6_int_or", 32'(INT_OR), 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
    end
    apb_rd(8'h00, rd, err);
    check("t6_dout_discarded", rd, 32'd0);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          @(posedge PCLK); #1;
          GPIO_IN = N'($urandom);
        end
        3: idle($urandom_range(1, 4));
        default: begin
          a = {2'($urandom_range(0, 2) == 0 ? 1 : 0) == 2'd1 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)), 2'($urandom)};
          a = {2'b00, a[5:0]};
          d = $urandom;
          if (a[7:2] == 6'd8) d = d & 32'h3;
          apb($urandom_range(0, 1) == 1, a, d, rd, err);
        end
      endcase
    end

    idle(10);
    check("apb_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
